// File: rtl/ssg_scan_ctrl_n.sv
// ssg_scan_ctrl_n: N-digit multiplexed seven-segment scanner with frame-synchronous
// shadow update, PWM dimming, blinking, leading-zero blanking and per-slot anode dead time.
module ssg_scan_ctrl_n #(
    parameter int NUM_DIGITS       = 8,
    parameter int CLK_FREQUENCY_HZ = 100000000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter int DIM_BITS         = 4,
    parameter int DEAD_CYCLES      = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] DIN,
    input  logic [8*NUM_DIGITS-1:0] SEG_DATA,
    input  logic                    USE_SEGMENT_DATA,
    input  logic [NUM_DIGITS-1:0]   BLANK,
    input  logic                    AUTOBLANK,
    input  logic [NUM_DIGITS-1:0]   BLINK,
    input  logic [2:0]              BLINK_RATE,
    input  logic [23:0]             REFRESH_RATE_DIV,
    input  logic [DIM_BITS-1:0]     BRIGHTNESS,
    input  logic                    UPDATE,
    output logic                    UPDATE_ACK,
    output logic                    FRAME_START,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [7:0]              SEG
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [31:0] F = 32'(CLK_FREQUENCY_HZ);
    localparam logic [31:0] BLINK_PER [8] = '{F << 1, F, F / 2, F / 4, F / 8, F / 16, F / 20, F / 24};
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODE_ACTIVE_LOW ? '1 : '0;
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [IW-1:0]           idx;
    logic [23:0]             slot;
    logic [DIM_BITS-1:0]     pwm;
    logic [31:0]             blink_cnt;
    logic                    phase;
    logic                    pending;
    logic                    fresh;
    logic [4*NUM_DIGITS-1:0] sh_din;
    logic [8*NUM_DIGITS-1:0] sh_seg;
    logic                    sh_use;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_blink;

    logic [23:0]             div_m1;
    logic                    slot_end;
    logic                    last;
    logic                    wrap;
    logic                    load;
    logic [31:0]             blink_lim;
    logic                    blink_end;
    logic                    z;
    logic [NUM_DIGITS-1:0]   zero_up;
    logic                    auto_bl;
    logic                    pwm_on;
    logic                    en;
    logic [3:0]              nib;
    logic [7:0]              pat;
    logic [NUM_DIGITS-1:0]   an_nx;

    // >= rather than == so a lowered divider ends the current slot at once
    assign div_m1    = REFRESH_RATE_DIV == '0 ? '0 : REFRESH_RATE_DIV - 24'd1;
    assign slot_end  = slot >= div_m1;
    assign last      = idx == IW'(NUM_DIGITS - 1);
    assign wrap      = slot_end && last;
    assign load      = wrap && (pending || UPDATE);
    assign blink_lim = BLINK_PER[BLINK_RATE] == '0 ? '0 : BLINK_PER[BLINK_RATE] - 32'd1;
    assign blink_end = blink_cnt >= blink_lim;

    // zero_up[k]: nibbles k..N-1 are all zero
    always_comb begin
        z = 1'b1;
        zero_up = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            z = z && sh_din[4*i +: 4] == 4'd0;
            zero_up[i] = z;
        end
    end

    assign nib     = sh_din[{idx, 2'b00} +: 4];
    assign auto_bl = !sh_use && AUTOBLANK && idx != '0 && zero_up[idx];
    assign pwm_on  = BRIGHTNESS == '0 ? 1'b0 : &BRIGHTNESS ? 1'b1 : pwm < BRIGHTNESS;
    assign en      = {8'd0, slot} >= 32'(DEAD_CYCLES) && !sh_blank[idx] && !auto_bl
                     && !(sh_blink[idx] && phase) && pwm_on;
    assign pat     = sh_use ? sh_seg[{idx, 3'b000} +: 8] : {HEX[nib], sh_seg[{idx, 3'b000}]};
    assign an_nx   = en ? ~(NUM_DIGITS'(1) << idx) : '1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            idx         <= '0;
            slot        <= '0;
            pwm         <= '0;
            blink_cnt   <= '0;
            phase       <= 1'b0;
            pending     <= 1'b0;
            fresh       <= 1'b1;
            sh_din      <= '0;
            sh_seg      <= '1;
            sh_use      <= 1'b0;
            sh_blank    <= '0;
            sh_blink    <= '0;
            UPDATE_ACK  <= 1'b0;
            FRAME_START <= 1'b0;
            AN          <= AN_OFF;
            SEG         <= SEG_OFF;
        end else begin
            slot        <= slot_end ? '0 : slot + 24'd1;
            idx         <= !slot_end ? idx : last ? '0 : idx + 1'b1;
            pwm         <= pwm + 1'b1;
            blink_cnt   <= blink_end ? '0 : blink_cnt + 32'd1;
            phase       <= phase ^ blink_end;
            pending     <= !load && (pending || UPDATE);
            fresh       <= 1'b0;
            UPDATE_ACK  <= load;
            FRAME_START <= fresh || wrap;
            AN          <= ANODE_ACTIVE_LOW ? an_nx : ~an_nx;
            SEG         <= SEG_ACTIVE_LOW ? pat : ~pat;
            if (load) begin
                sh_din   <= DIN;
                sh_seg   <= SEG_DATA;
                sh_use   <= USE_SEGMENT_DATA;
                sh_blank <= BLANK;
                sh_blink <= BLINK;
            end
        end
    end
endmodule

// File: tb/tb_ssg_scan_ctrl_n.sv
// tb_ssg_scan_ctrl_n: directed checks of a 4-digit scanner (4-clock slots, 1 dead clock,
// 2-bit PWM, 2400 Hz nominal clock so blink rate 7 toggles every 100 clocks).
module tb_ssg_scan_ctrl_n;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic [31:0] seg_data = '1;
    logic        use_seg = 1'b0;
    logic [3:0]  blank = '0;
    logic        autoblank = 1'b0;
    logic [3:0]  blink = '0;
    logic [2:0]  blink_rate = '0;
    logic [23:0] refresh = 24'd4;
    logic [1:0]  brightness = 2'd3;
    logic        update = 1'b0;
    logic        update_ack;
    logic        frame_start;
    logic [3:0]  an;
    logic [7:0]  seg;
    int          total = 0;
    int          bad = 0;

    ssg_scan_ctrl_n #(
        .NUM_DIGITS(4), .CLK_FREQUENCY_HZ(2400), .ANODE_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW(1'b1), .DIM_BITS(2), .DEAD_CYCLES(1)
    ) dut (
        .CLK(clk), .RESET(rst), .DIN(din), .SEG_DATA(seg_data), .USE_SEGMENT_DATA(use_seg),
        .BLANK(blank), .AUTOBLANK(autoblank), .BLINK(blink), .BLINK_RATE(blink_rate),
        .REFRESH_RATE_DIV(refresh), .BRIGHTNESS(brightness), .UPDATE(update),
        .UPDATE_ACK(update_ack), .FRAME_START(frame_start), .AN(an), .SEG(seg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame;
        int i = 0;
        do begin
            tick;
            i++;
        end while (!frame_start && i < 64);
        chk("sync", frame_start, 1'b1);
    endtask

    // Starts on a FRAME_START sample; sample k shows position k-1 of the frame.
    task automatic frame(input string tag, input logic [3:0] lit, input logic [31:0] segs,
                         input int upd_at, input logic [15:0] nd, input int acks);
        int d, s, n;
        logic [3:0] e;
        n = 0;
        for (int k = 1; k <= 16; k++) begin
            tick;
            d = (k - 1) / 4;
            s = (k - 1) % 4;
            e = (s == 0 || !lit[d]) ? 4'hF : ~(4'b1 << d);
            chk($sformatf("%s_an%0d", tag, k), an, e);
            chk($sformatf("%s_seg%0d", tag, k), seg, segs[8*d +: 8]);
            n += int'(update_ack);
            if (k == upd_at) begin
                din = nd;
                update = 1'b1;
            end else update = 1'b0;
        end
        chk({tag, "_fs"}, frame_start, 1'b1);
        chk({tag, "_acks"}, n, acks);
    endtask

    task automatic pwm_run(input logic [1:0] b, input int div, input int n);
        int p, s, d;
        logic on;
        logic [3:0] e;
        rst = 1'b1;
        brightness = b;
        refresh = 24'(div);
        tick;
        tick;
        rst = 1'b0;
        for (int k = 1; k <= n; k++) begin
            tick;
            p = k - 1;
            s = p % div;
            d = (p / div) % 4;
            on = (b == 2'd3) || ((p % 4) < b);
            e = (s >= 1 && on) ? ~(4'b1 << d) : 4'hF;
            chk($sformatf("pwm%0d_an%0d", b, k), an, e);
        end
    endtask

    initial begin
        int p, d, s;
        logic [3:0] e;
        logic [3:0] exp_div [6] = '{4'hE, 4'hF, 4'hD, 4'hD, 4'hF, 4'hB};
        repeat (2) tick;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_ack", update_ack, 1'b0);
        chk("rst_fs", frame_start, 1'b0);
        rst = 1'b0;
        tick;
        chk("fs_first", frame_start, 1'b1);
        din = 16'h1234;
        seg_data = 32'hFFFF_FFFE;
        update = 1'b1;
        tick;
        update = 1'b0;
        wait_frame;
        chk("ack_first", update_ack, 1'b1);
        frame("t1", 4'hF, 32'hF349_6132, 0, 16'h1234, 0);
        frame("t2", 4'hF, 32'hF349_6132, 6, 16'h5678, 1);
        frame("t3", 4'hF, 32'h2505_F100, 0, 16'h5678, 0);
        autoblank = 1'b1;
        frame("ab0", 4'hF, 32'h2505_F100, 2, 16'h0000, 1);
        frame("ab1", 4'h1, 32'h8181_8180, 2, 16'h0050, 1);
        frame("ab2", 4'h3, 32'h8181_2580, 0, 16'h0050, 0);
        use_seg = 1'b1;
        seg_data = 32'h8844_2211;
        blank = 4'b0100;
        frame("raw0", 4'h3, 32'h8181_2580, 2, 16'h0050, 1);
        frame("raw1", 4'hB, 32'h8844_2211, 0, 16'h0050, 0);
        tick;
        update = 1'b1;
        tick;
        chk("pre_an", an, 4'hE);
        chk("pre_seg", seg, 8'h11);
        update = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("async_an", an, 4'hF);
        chk("async_seg", seg, 8'hFF);
        chk("async_ack", update_ack, 1'b0);
        use_seg = 1'b0;
        seg_data = 32'hFFFF_FFFE;
        din = 16'h1234;
        blank = '0;
        blink = 4'b0001;
        blink_rate = 3'd7;
        autoblank = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            tick;
            p = k - 1;
            d = (p % 16) / 4;
            s = p % 4;
            e = (s == 0 || (d == 0 && (p / 100) % 2 == 1)) ? 4'hF : ~(4'b1 << d);
            chk($sformatf("blink_an%0d", k), an, e);
            if (k == 1 || k == 16 || k == 32) chk($sformatf("rel_fs%0d", k), frame_start, 1'b1);
            if (k == 2) chk("rel_fs2", frame_start, 1'b0);
            if (k == 16) chk("lost_pending_ack", update_ack, 1'b0);
            if (k == 32) chk("blink_ack", update_ack, 1'b1);
            if (k == 17) chk("rel_seg17", seg, 8'h81);
            if (k == 40) chk("rel_seg40", seg, 8'h61);
            update = k == 20;
        end
        blink = '0;
        pwm_run(2'd1, 5, 80);
        pwm_run(2'd2, 5, 40);
        pwm_run(2'd0, 5, 40);
        rst = 1'b1;
        brightness = 2'd3;
        refresh = 24'd8;
        tick;
        tick;
        rst = 1'b0;
        repeat (6) tick;
        refresh = 24'd3;
        for (int k = 7; k <= 12; k++) begin
            tick;
            chk($sformatf("div_low%0d", k), an, exp_div[k-7]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
